// File: rtl/bus_scheduler.sv
// Round-robin arbiter for two bus masters onto three slaves, with ready-timeout and hold watchdog.
// slave_grant one cycle after the request is sampled; grants drop for a single RELEASE turnaround cycle.
module bus_scheduler #(
   parameter int READY_TIMEOUT = 16,
   parameter int MAX_HOLD      = 256,
   parameter int CNT_W         = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m1_request,
   input  logic       m2_request,
   input  logic [1:0] m1_slave_sel,
   input  logic [1:0] m2_slave_sel,
   input  logic       m1_tx_done,
   input  logic       m2_tx_done,
   input  logic [2:0] slave_ready,
   output logic       m1_grant,
   output logic       m2_grant,
   output logic       bus_grant,
   output logic [1:0] slave_grant,
   output logic       busy,
   output logic       timeout_err,
   output logic       sel_err
);
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_RDY = 2'd1, ACTIVE = 2'd2, RELEASE = 2'd3} state_t;

   localparam logic [CNT_W-1:0] RDY_LAST  = CNT_W'(READY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic             bus_nxt;
   logic [1:0]       slv_nxt;
   logic             last_winner, last_nxt;
   logic             terr_nxt, serr_nxt;
   logic             pick_m2;
   logic [1:0]       pick_sel;
   logic             win_req, win_done, rdy_hit;

   // bus_grant doubles as the latched winner: 0 = master 1, 1 = master 2
   assign pick_m2  = m2_request & (~m1_request | ~last_winner);
   assign pick_sel = pick_m2 ? m2_slave_sel : m1_slave_sel;
   assign win_req  = bus_grant ? m2_request : m1_request;
   assign win_done = bus_grant ? m2_tx_done : m1_tx_done;
   assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

   assign m1_grant = (state == ACTIVE) & ~bus_grant;
   assign m2_grant = (state == ACTIVE) &  bus_grant;
   assign busy     = (state != IDLE);

   always_comb begin
      rdy_hit = 1'b0;
      case (slave_grant)
         2'd1:    rdy_hit = slave_ready[0];
         2'd2:    rdy_hit = slave_ready[1];
         2'd3:    rdy_hit = slave_ready[2];
         default: rdy_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bus_nxt   = bus_grant;
      slv_nxt   = slave_grant;
      last_nxt  = last_winner;
      terr_nxt  = 1'b0;
      serr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (m1_request | m2_request) begin
               if (pick_sel == 2'd0) begin
                  serr_nxt = 1'b1;
                  last_nxt = pick_m2;
               end else begin
                  bus_nxt   = pick_m2;
                  slv_nxt   = pick_sel;
                  cnt_nxt   = '0;
                  state_nxt = WAIT_RDY;
               end
            end
         end
         WAIT_RDY: begin
            if (!win_req) begin
               slv_nxt   = 2'd0;
               state_nxt = RELEASE;
            end else if (rdy_hit) begin
               cnt_nxt   = '0;
               state_nxt = ACTIVE;
            end else if (cnt == RDY_LAST) begin
               terr_nxt  = 1'b1;
               slv_nxt   = 2'd0;
               state_nxt = RELEASE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         ACTIVE: begin
            // watchdog checked first so a coincident tx_done still reports the expiry
            if (cnt == HOLD_LAST) begin
               terr_nxt  = 1'b1;
               slv_nxt   = 2'd0;
               state_nxt = RELEASE;
            end else if (win_done || !win_req) begin
               slv_nxt   = 2'd0;
               state_nxt = RELEASE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         RELEASE: begin
            last_nxt  = bus_grant;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bus_grant   <= 1'b0;
         slave_grant <= 2'd0;
         last_winner <= 1'b1;
         timeout_err <= 1'b0;
         sel_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         bus_grant   <= bus_nxt;
         slave_grant <= slv_nxt;
         last_winner <= last_nxt;
         timeout_err <= terr_nxt;
         sel_err     <= serr_nxt;
      end
   end
endmodule

// File: tb/tb_bus_scheduler.sv
// Directed bench for bus_scheduler (MAX_HOLD shortened to 8); outputs observed 1ns after each rising edge.
module tb_bus_scheduler;
   logic       clk = 1'b0;
   logic       reset;
   logic       m1_request, m2_request;
   logic [1:0] m1_slave_sel, m2_slave_sel;
   logic       m1_tx_done, m2_tx_done;
   logic [2:0] slave_ready;
   logic       m1_grant, m2_grant, bus_grant, busy, timeout_err, sel_err;
   logic [1:0] slave_grant;

   int total = 0;
   int bad   = 0;

   bus_scheduler #(.READY_TIMEOUT(16), .MAX_HOLD(8), .CNT_W(9)) dut (
      .clk(clk), .reset(reset),
      .m1_request(m1_request), .m2_request(m2_request),
      .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
      .m1_tx_done(m1_tx_done), .m2_tx_done(m2_tx_done),
      .slave_ready(slave_ready),
      .m1_grant(m1_grant), .m2_grant(m2_grant), .bus_grant(bus_grant),
      .slave_grant(slave_grant), .busy(busy),
      .timeout_err(timeout_err), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {m1_grant, m2_grant, bus_grant, slave_grant[1:0], busy, timeout_err, sel_err}
   function automatic logic [7:0] outs();
      return {m1_grant, m2_grant, bus_grant, slave_grant, busy, timeout_err, sel_err};
   endfunction

   initial begin
      reset = 1'b0;
      m1_request = 0; m2_request = 0; m1_slave_sel = 0; m2_slave_sel = 0;
      m1_tx_done = 0; m2_tx_done = 0; slave_ready = 3'b000;
      step();
      check("reset_outs", outs(), 8'b000_00_000);
      reset = 1'b1;
      step();
      check("idle_after_reset", outs(), 8'b000_00_000);

      // single master 1 transaction to slave 2
      m1_request = 1; m1_slave_sel = 2'd2; slave_ready = 3'b010;
      step();
      check("t1_wait_rdy", outs(), 8'b000_10_100);
      step();
      check("t1_active", outs(), 8'b100_10_100);
      m1_tx_done = 1;
      step();
      check("t1_release", outs(), 8'b000_00_100);
      m1_tx_done = 0; m1_request = 0;
      step();
      check("t1_idle", outs(), 8'b000_00_000);

      // master 2 ready timeout, slave 3 never ready
      m2_request = 1; m2_slave_sel = 2'd3; slave_ready = 3'b000;
      step();
      check("t3_wait_entry", outs(), 8'b001_11_100);
      for (int i = 1; i <= 15; i++) begin
         step();
         check($sformatf("t3_waiting_%0d", i), {m2_grant, timeout_err, busy}, 3'b001);
      end
      step();
      check("t3_timeout", outs(), 8'b001_00_110);
      m2_request = 0;
      step();
      check("t3_idle", outs(), 8'b001_00_000);

      // master 1 wins with sel=0 -> sel_err, then master 2 is served
      m1_request = 1; m1_slave_sel = 2'd0; m2_request = 1; m2_slave_sel = 2'd1; slave_ready = 3'b001;
      step();
      check("t5_sel_err", {sel_err, busy, slave_grant, m1_grant, m2_grant}, 6'b10_00_00);
      step();
      check("t5_m2_wait", outs(), 8'b001_01_100);
      step();
      check("t5_m2_active", outs(), 8'b011_01_100);
      m1_request = 0; m2_request = 0;
      step();
      check("t5_release", outs(), 8'b001_00_100);
      step();
      check("t5_idle", busy, 1'b0);

      // back-to-back contention: M1, M2, M1
      m1_request = 1; m1_slave_sel = 2'd1; m2_request = 1; m2_slave_sel = 2'd3; slave_ready = 3'b111;
      step();
      check("t2_a_wait", outs(), 8'b000_01_100);
      step();
      check("t2_a_active", outs(), 8'b100_01_100);
      m1_tx_done = 1;
      step();
      check("t2_a_release", outs(), 8'b000_00_100);
      m1_tx_done = 0;
      step();
      check("t2_gap_idle", busy, 1'b0);
      step();
      check("t2_b_wait", outs(), 8'b001_11_100);
      step();
      check("t2_b_active", outs(), 8'b011_11_100);
      m2_tx_done = 1;
      step();
      check("t2_b_release", outs(), 8'b001_00_100);
      m2_tx_done = 0;
      step();
      check("t2_gap2_idle", busy, 1'b0);
      step();
      check("t2_c_wait", outs(), 8'b000_01_100);
      step();
      check("t2_c_active", outs(), 8'b100_01_100);
      m1_request = 0; m2_request = 0;
      step();
      check("t2_c_release", outs(), 8'b000_00_100);
      step();
      check("t2_idle", busy, 1'b0);

      // hold watchdog: m1 never finishes; a stray m2_tx_done is ignored
      m1_request = 1; m1_slave_sel = 2'd2; slave_ready = 3'b010;
      step();
      step();
      check("t4_active_0", {m1_grant, timeout_err}, 2'b10);
      m2_tx_done = 1;
      for (int i = 1; i <= 7; i++) begin
         step();
         m2_tx_done = 0;
         check($sformatf("t4_active_%0d", i), {m1_grant, timeout_err, busy}, 3'b101);
      end
      step();
      check("t4_watchdog", outs(), 8'b000_00_110);
      m1_request = 0;
      step();
      check("t4_idle", outs(), 8'b000_00_000);

      // asynchronous reset during ACTIVE
      m1_request = 1; m1_slave_sel = 2'd2; slave_ready = 3'b010;
      step();
      step();
      check("t6_active", m1_grant, 1'b1);
      reset = 1'b0;
      #2;
      check("t6_async_reset", outs(), 8'b000_00_000);
      m2_request = 1; m2_slave_sel = 2'd1;
      step();
      check("t6_held_reset", outs(), 8'b000_00_000);
      reset = 1'b1;
      step();
      check("t6_m1_wins", outs(), 8'b000_10_100);
      m1_request = 0; m2_request = 0;
      step();
      check("t6_release", outs(), 8'b000_00_100);
      step();
      check("t6_idle", outs(), 8'b000_00_000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
